cmul_imag_arbiter: RTL

- Shares one pipelined complex-by-imaginary multiplier between two requesters, A and B.
- The multiplier computes cr = -ai*bi and ci = ar*bi.
- Each requester has a valid/ready port. A round-robin arbiter issues at most one operation per cycle into a LAT-deep pipeline.
- Results leave on a single output stream tagged with the requester id. A downstream out_ready stalls the whole pipeline.
- Sits between the FFT stage-control logic (A) and the coefficient-rotation path (B), in front of the shared multiplier.

---
 rtl/cmul_imag_arbiter_if.sv | 44 ++++
 rtl/cmul_imag_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cmul_imag_arbiter_if.sv
// Handshake and data bundle for the shared complex-by-imaginary multiplier.
// Carries the two requester ports (A, B) and the tagged result stream.
// The slave modport is the arbiter; the master modport is the environment
// that drives the requests and consumes the results.
interface cmul_imag_arbiter_if #(
  parameter int WL     = 14,
  parameter int WL_out = 2 * WL
);
  logic                     a_valid;
  logic                     a_ready;
  logic signed [WL-1:0]     a_ar;
  logic signed [WL-1:0]     a_ai;
  logic signed [WL-1:0]     a_bi;

  logic                     b_valid;
  logic                     b_ready;
  logic signed [WL-1:0]     b_ar;
  logic signed [WL-1:0]     b_ai;
  logic signed [WL-1:0]     b_bi;

  logic                     out_valid;
  logic                     out_ready;
  logic                     out_id;
  logic signed [WL_out-1:0] cr;
  logic signed [WL_out-1:0] ci;

  modport slave (
    input  a_valid, a_ar, a_ai, a_bi,
    output a_ready,
    input  b_valid, b_ar, b_ai, b_bi,
    output b_ready,
    output out_valid, out_id, cr, ci,
    input  out_ready
  );

  modport master (
    output a_valid, a_ar, a_ai, a_bi,
    input  a_ready,
    output b_valid, b_ar, b_ai, b_bi,
    input  b_ready,
    input  out_valid, out_id, cr, ci,
    output out_ready
  );
endinterface

// File: rtl/cmul_imag_arbiter.sv
// Round-robin arbiter in front of one pipelined complex-by-imaginary
// multiplier: cr = -(ai*bi), ci = ar*bi, full precision.
// Requester A and B share the pipe; results come out in acceptance order
// tagged with out_id (0 = A, 1 = B). A held result (out_valid & ~out_ready)
// freezes every stage and blocks new grants.
// Pipeline: stage 1 holds the accepted operands, stage 2 holds the products,
// stages 3..LAT+1 are delay stages; stage LAT+1 drives the outputs, so a
// result appears LAT edges after the accepting edge.
// Optional macro CMUL_ARB_STAT_EN adds accept/stall statistics counters
// (cnt_a, cnt_b, cnt_stall) with a synchronous clear (stat_clr).
module cmul_imag_arbiter #(
  parameter int WL     = 14,
  parameter int WL_out = 2 * WL,
  parameter int LAT    = 3
) (
  input  logic        clk,
  input  logic        reset,
`ifdef CMUL_ARB_STAT_EN
  input  logic        stat_clr,
  output logic [15:0] cnt_a,
  output logic [15:0] cnt_b,
  output logic [15:0] cnt_stall,
`endif
  cmul_imag_arbiter_if.slave bif
);

  localparam int D = LAT + 1;

  // pointer encoding for the round-robin favourite
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic                     stall;
  logic                     grant_a;
  logic                     grant_b;
  logic                     accept;
  logic                     ptr;

  logic [D:1]               vld;
  logic [D:1]               sid;
  logic [D:1]               vin;
  logic [D:1]               sin;

  logic signed [WL-1:0]     sel_ar;
  logic signed [WL-1:0]     sel_ai;
  logic signed [WL-1:0]     sel_bi;
  logic signed [WL-1:0]     s1_ar;
  logic signed [WL-1:0]     s1_ai;
  logic signed [WL-1:0]     s1_bi;

  logic signed [WL_out-1:0] ext_ar;
  logic signed [WL_out-1:0] ext_ai;
  logic signed [WL_out-1:0] ext_bi;
  logic signed [WL_out-1:0] p_cr;
  logic signed [WL_out-1:0] p_ci;
  logic signed [WL_out-1:0] pcr [2:D];
  logic signed [WL_out-1:0] pci [2:D];

  assign stall = vld[D] & ~bif.out_ready;

  // Grant selection: a lone requester always wins, a tie goes to the pointer.
  // Readies depend on the valids only combinationally, never the reverse.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!stall) begin
      if (bif.a_valid && bif.b_valid) begin
        grant_a = (ptr == PTR_A);
        grant_b = (ptr == PTR_B);
      end else begin
        grant_a = bif.a_valid;
        grant_b = bif.b_valid;
      end
    end
  end

  assign accept      = grant_a | grant_b;
  assign bif.a_ready = grant_a;
  assign bif.b_ready = grant_b;

  // Pointer flips only after a contested grant; stalled ties leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= PTR_A;
    end else if (!stall && bif.a_valid && bif.b_valid) begin
      ptr <= ~ptr;
    end
  end

  assign sel_ar = grant_b ? bif.b_ar : bif.a_ar;
  assign sel_ai = grant_b ? bif.b_ai : bif.a_ai;
  assign sel_bi = grant_b ? bif.b_bi : bif.a_bi;

  // Next-stage valid/id: stage 1 takes the grant, later stages take their
  // predecessor. Bubbles travel with the flow and are never squeezed out.
  assign vin = {vld[D-1:1], accept};
  assign sin = {sid[D-1:1], grant_b};

  // Valid and owner-id chain; ids only update under a valid entry so out_id
  // keeps the last owner while a bubble sits at the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      sid <= '0;
    end else if (!stall) begin
      vld <= vin;
      for (int k = 1; k <= D; k++) begin
        if (vin[k]) sid[k] <= sin[k];
      end
    end
  end

  // Stage 1: capture the granted operand triple.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_ar <= '0;
      s1_ai <= '0;
      s1_bi <= '0;
    end else if (accept) begin
      s1_ar <= sel_ar;
      s1_ai <= sel_ai;
      s1_bi <= sel_bi;
    end
  end

  // Sign-extend before multiplying so the product is formed at full width;
  // with WL_out >= 2*WL even (-2^(WL-1))^2 and its negation are exact.
  assign ext_ar = WL_out'(s1_ar);
  assign ext_ai = WL_out'(s1_ai);
  assign ext_bi = WL_out'(s1_bi);
  assign p_ci   = ext_ar * ext_bi;
  assign p_cr   = -(ext_ai * ext_bi);

  // Product and delay stages; data only moves with a valid entry, which is
  // what keeps cr/ci at their last value behind a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 2; k <= D; k++) begin
        pcr[k] <= '0;
        pci[k] <= '0;
      end
    end else if (!stall) begin
      if (vld[1]) begin
        pcr[2] <= p_cr;
        pci[2] <= p_ci;
      end
      for (int k = 3; k <= D; k++) begin
        if (vld[k-1]) begin
          pcr[k] <= pcr[k-1];
          pci[k] <= pci[k-1];
        end
      end
    end
  end

  assign bif.out_valid = vld[D];
  assign bif.out_id    = sid[D];
  assign bif.cr        = pcr[D];
  assign bif.ci        = pci[D];

`ifdef CMUL_ARB_STAT_EN
  // Accept and stall statistics; clear beats increment, all wrap at 2^16.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_stall <= '0;
    end else if (stat_clr) begin
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_stall <= '0;
    end else begin
      if (grant_a) cnt_a     <= cnt_a + 16'd1;
      if (grant_b) cnt_b     <= cnt_b + 16'd1;
      if (stall)   cnt_stall <= cnt_stall + 16'd1;
    end
  end
`endif

endmodule
